pipelined_carry_select_adder: RTL and testbench
===============================================

// Module: pipelined_carry_select_adder
// PURPOSE
//   WIDTH-bit add/subtract unit built from BLOCK_LEN-bit carry-select blocks.
//   Blocks are grouped into pipeline stages with a valid/ready handshake.
//   Each block precomputes its carry chains for cin=0 and cin=1 and selects
//   by the incoming carry. Serves as the datapath adder for wide ALU and
//   accumulator paths where a single-cycle carry-select ripple misses timing.
// PARAMETERS
//   WIDTH            32  operand width; must be a multiple of BLOCK_LEN
//   BLOCK_LEN         4  bits per carry-select block (>=2)
//   BLOCKS_PER_STAGE  2  carry-select blocks evaluated per pipeline stage (>=1)
//   Derived: NB = WIDTH/BLOCK_LEN; STAGES = ceil(NB/BLOCKS_PER_STAGE)
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operands present this cycle
//   in_ready   out  1      unit accepts operands this cycle
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in (add mode only)
//   sub        in   1      1: a-b (b inverted, carry-in forced to 1, cin ignored)
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts result
//   sum        out  WIDTH  result
//   cout       out  1      carry-out of MSB (sub: 1 = no borrow)
//   ovf        out  1      signed overflow: carry into MSB XOR carry out of MSB
// BEHAVIOUR
//   - One clock; reset is asynchronous and active-low. While rst_n=0, every
//     stage valid and data register clears to 0: out_valid=0, sum=0,
//     cout=0, ovf=0. If reset asserts mid-operation, in-flight ops are dropped.
//   - Block math: p=a|b, g=a&b per bit. Two ripple chains run, seeded 0 and 1.
//     The block carry-in selects between them. Sum bit = a^b^c.
//   - Stage k evaluates blocks [k*BPS, min((k+1)*BPS,NB)-1] and registers:
//     its sum slice, its carry-out, and all not-yet-summed operand bits.
//   - Latency: exactly STAGES cycles from accept (in_valid&in_ready) to
//     out_valid, with no stalls. Throughput is one op per cycle.
//   - Handshake: advance = ~out_valid | out_ready; in_ready = advance.
//     When advance=1, all stage registers shift one stage. When advance=0,
//     all registers hold. A bubble (in_valid=0 on an advance) shifts in
//     valid=0.
//   - a/b/cin/sub are sampled only on accept. The outputs
//     sum/cout/ovf/out_valid stay stable while out_valid&~out_ready.
//   - Ordering is strict FIFO. No reordering, and no op is dropped outside reset.
//   - Results are modulo 2^WIDTH. cout/ovf come from the final stage's MSB block.
//   - Edge cases:
//     * STAGES=1: purely registered, latency 1.
//     * NB not divisible by BPS: the last stage holds fewer blocks.
//     * Simultaneous accept and output consume: both occur; out_valid stays high.
// TESTING (WIDTH=16, BLOCK_LEN=4, BPS=2 -> STAGES=2)
//   1 Reset: rst_n=0 async mid-cycle -> out_valid/sum/cout/ovf = 0 immediately.
//     After release: in_ready=1.
//   2 Add: a=16'hFFFF, b=16'h0001, cin=0 -> two cycles later:
//     sum=16'h0000, cout=1, ovf=0.
//   3 Sub: a=16'h8000, b=16'h0001, sub=1 -> sum=16'h7FFF, cout=1, ovf=1.
//     Add: a=16'h7FFF, b=1 -> sum=16'h8000, ovf=1.
//   4 Back-to-back: 100 random ops at in_valid=1, out_ready=1 -> one result per
//     cycle after 2-cycle fill. Results match a+b+cin in order.
//   5 Backpressure: out_ready=0 for 5 cycles with the pipe full -> in_ready=0 and
//     outputs held. On release, no loss or duplication; the scoreboard matches.
//   6 Random in_valid/out_ready (50%), carry ripple across all 4 blocks
//     (a=16'h0FFF, b=16'h0001) -> the 16'h1000 result appears in correct order.

Source files
------------

// File: rtl/pipelined_carry_select_adder.sv
// -----------------------------------------------------------------------------
// pipelined_carry_select_adder
//   WIDTH-bit add/subtract unit built from BLOCK_LEN-bit carry-select blocks.
//   Each block ripples two carry chains (seeded 0 and 1) and the incoming
//   block carry picks one. BLOCKS_PER_STAGE blocks are evaluated per pipeline
//   stage. Each stage registers the sum bits finished so far, its carry-out,
//   and only the operand bits that later stages still need. All stages shift
//   together under a single valid/ready handshake.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operands present this cycle
//   in_ready   out  1      unit accepts operands this cycle
//   a, b       in   WIDTH  operands
//   cin        in   1      carry-in (add mode only)
//   sub        in   1      1: a-b (b inverted, carry-in forced to 1)
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts result
//   sum        out  WIDTH  result, modulo 2^WIDTH
//   cout       out  1      carry-out of MSB (sub: 1 = no borrow)
//   ovf        out  1      signed overflow
// -----------------------------------------------------------------------------
module pipelined_carry_select_adder #(
  parameter int WIDTH            = 32,
  parameter int BLOCK_LEN        = 4,
  parameter int BLOCKS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NB     = WIDTH / BLOCK_LEN;
  localparam int STAGES = (NB + BLOCKS_PER_STAGE - 1) / BLOCKS_PER_STAGE;

  // Exclusive upper block index handled by stage s.
  function automatic int last_blk(input int s);
    return ((s + 1) * BLOCKS_PER_STAGE < NB) ? (s + 1) * BLOCKS_PER_STAGE : NB;
  endfunction

  // Sum bits complete after stage s, and operand bits still pending.
  function automatic int done_w(input int s);
    return last_blk(s) * BLOCK_LEN;
  endfunction

  function automatic int pend_w(input int s);
    return WIDTH - done_w(s);
  endfunction

  // Offsets of each stage's slice inside the flat hand-off vectors.
  function automatic int sum_off(input int s);
    int o = 0;
    for (int t = 0; t < s; t++) o += done_w(t);
    return o;
  endfunction

  function automatic int pend_off(input int s);
    int o = 0;
    for (int t = 0; t < s; t++) o += pend_w(t);
    return o;
  endfunction

  localparam int SUM_TOT  = (STAGES > 1) ? sum_off(STAGES - 1)  : 1;
  localparam int PEND_TOT = (STAGES > 1) ? pend_off(STAGES - 1) : 1;

  // One carry-select block: returns {carry_out, sum[BLOCK_LEN-1:0]}.
  function automatic logic [BLOCK_LEN:0] csel_block(
    input logic [BLOCK_LEN-1:0] x,
    input logic [BLOCK_LEN-1:0] y,
    input logic                 ci
  );
    logic [BLOCK_LEN-1:0] p, g, s0, s1;
    logic                 c0, c1;
    p  = x | y;
    g  = x & y;
    s0 = '0;
    s1 = '0;
    c0 = 1'b0;
    c1 = 1'b1;
    for (int i = 0; i < BLOCK_LEN; i++) begin
      s0[i] = x[i] ^ y[i] ^ c0;
      s1[i] = x[i] ^ y[i] ^ c1;
      c0    = g[i] | (p[i] & c0);
      c1    = g[i] | (p[i] & c1);
    end
    return ci ? {c1, s1} : {c0, s0};
  endfunction

  logic                advance;
  logic [STAGES-1:0]   vld_vec;
  logic [STAGES-1:0]   c_vec;
  logic [SUM_TOT-1:0]  sum_flat;
  logic [PEND_TOT-1:0] a_flat;
  logic [PEND_TOT-1:0] b_flat;

  assign advance   = ~out_valid | out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_vec[STAGES-1];
  assign cout      = c_vec[STAGES-1];

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int FIRST = s * BLOCKS_PER_STAGE;
    localparam int NBLK  = last_blk(s) - FIRST;
    localparam int IN_W  = WIDTH - FIRST * BLOCK_LEN;
    localparam int NEW_W = NBLK * BLOCK_LEN;
    localparam int SW    = done_w(s);

    logic [IN_W-1:0]  a_src, b_src;
    logic             c_src, vld_src;
    logic [NEW_W-1:0] new_sum;
    logic             c_new;
    logic [SW-1:0]    sum_nx;
    logic [SW-1:0]    sum_p;
    logic             c_p, vld_p;

    if (s == 0) begin : g_src
      // Subtraction is a + ~b + 1; cin is ignored in that mode.
      assign a_src   = a;
      assign b_src   = b ^ {WIDTH{sub}};
      assign c_src   = sub | cin;
      assign vld_src = in_valid;
      assign sum_nx  = new_sum;
    end else begin : g_src
      assign a_src   = a_flat[pend_off(s-1) +: IN_W];
      assign b_src   = b_flat[pend_off(s-1) +: IN_W];
      assign c_src   = c_vec[s-1];
      assign vld_src = vld_vec[s-1];
      assign sum_nx  = {new_sum, sum_flat[sum_off(s-1) +: FIRST*BLOCK_LEN]};
    end

    always_comb begin
      logic [BLOCK_LEN:0] r;
      logic               c;
      r       = '0;
      c       = c_src;
      new_sum = '0;
      for (int k = 0; k < NBLK; k++) begin
        r = csel_block(a_src[k*BLOCK_LEN +: BLOCK_LEN],
                       b_src[k*BLOCK_LEN +: BLOCK_LEN], c);
        new_sum[k*BLOCK_LEN +: BLOCK_LEN] = r[BLOCK_LEN-1:0];
        c = r[BLOCK_LEN];
      end
      c_new = c;
    end

    // ---- stage s register boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p <= 1'b0;
        c_p   <= 1'b0;
        sum_p <= '0;
      end else if (advance) begin
        vld_p <= vld_src;
        c_p   <= c_new;
        sum_p <= sum_nx;
      end
    end

    assign vld_vec[s] = vld_p;
    assign c_vec[s]   = c_p;

    if (s < STAGES - 1) begin : g_ops
      logic [pend_w(s)-1:0] a_p, b_p;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_p <= '0;
          b_p <= '0;
        end else if (advance) begin
          a_p <= a_src[IN_W-1:NEW_W];
          b_p <= b_src[IN_W-1:NEW_W];
        end
      end

      assign a_flat[pend_off(s) +: pend_w(s)] = a_p;
      assign b_flat[pend_off(s) +: pend_w(s)] = b_p;
      assign sum_flat[sum_off(s) +: SW]       = sum_p;
    end else begin : g_out
      logic c_msb, ovf_p;

      // Carry into the MSB recovered from the MSB sum bit: c = s ^ a ^ b.
      assign c_msb = a_src[IN_W-1] ^ b_src[IN_W-1] ^ new_sum[NEW_W-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_p <= 1'b0;
        end else if (advance) begin
          ovf_p <= c_msb ^ c_new;
        end
      end

      assign sum = sum_p;
      assign ovf = ovf_p;
    end
  end

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_carry_select_adder
//   Self-checking bench for the 16-bit, 4-bit-block, 2-blocks-per-stage
//   configuration (two pipeline stages). Expected results are queued at
//   accept time and compared in order as results are consumed.
// -----------------------------------------------------------------------------
module tb_pipelined_carry_select_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        cin, sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout, ovf;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [17:0] exp_q[$];
  logic [17:0] mon_exp;
  logic        rand_rdy = 1'b0;

  pipelined_carry_select_adder #(
    .WIDTH(16),
    .BLOCK_LEN(4),
    .BLOCKS_PER_STAGE(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .cin(cin),
    .sub(sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum(sum),
    .cout(cout),
    .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference result {cout, ovf, sum} from plain integer arithmetic.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic s);
    logic [15:0] yy;
    logic [16:0] full;
    logic        ov;
    yy   = s ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + {16'd0, (s | ci)};
    ov   = (x[15] == yy[15]) && (full[15] != x[15]);
    return {full[16], ov, full[15:0]};
  endfunction

  // Present one op and hold it until accepted; queue its expected result.
  task automatic send(input logic [15:0] xa, input logic [15:0] xb, input logic xc,
                      input logic xs, input logic [17:0] e, output int waited);
    logic acc;
    a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1;
    waited = 0;
    acc = 1'b0;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      waited++;
      if (acc || waited >= 200) break;
    end
    if (acc) exp_q.push_back(e);
    else check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  // Scoreboard: compare every consumed result against the queue head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_result", {31'd0, out_valid}, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", {14'd0, cout, ovf, sum}, {14'd0, mon_exp});
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int total;
    logic [15:0] ra, rb;
    logic rc, rs;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sum", {16'd0, sum}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a cycle with a result on the output.
    out_ready = 1'b0;
    send(16'h1234, 16'h4321, 1'b0, 1'b0, {1'b0, 1'b0, 16'h5555}, w);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    check("pre_rst_sum", {16'd0, sum}, 32'h5555);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_sum", {16'd0, sum}, 32'd0);
    check("async_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Latency: result appears exactly two cycles after accept.
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h0000}, w);
    @(negedge clk);
    check("latency_e1", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("latency_e2", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;

    // Directed add/sub vectors.
    send(16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF}, w);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h8000}, w);
    send(16'h0000, 16'h0001, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFF}, w);
    send(16'h0005, 16'h0003, 1'b0, 1'b1, {1'b1, 1'b0, 16'h0002}, w);
    send(16'h0005, 16'h0003, 1'b1, 1'b1, {1'b1, 1'b0, 16'h0002}, w);
    send(16'h1234, 16'h4321, 1'b1, 1'b0, {1'b0, 1'b0, 16'h5556}, w);
    send(16'h8000, 16'h8000, 1'b0, 1'b0, {1'b1, 1'b1, 16'h0000}, w);
    drain();

    // Backpressure with the pipe full: input stalls and output holds.
    out_ready = 1'b0;
    send(16'h0001, 16'h0002, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0003}, w);
    send(16'h00FF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0100}, w);
    fork
      send(16'hF000, 16'h1000, 1'b0, 1'b0, {1'b1, 1'b0, 16'h0000}, w);
      begin
        repeat (5) begin
          @(negedge clk);
          check("bp_in_ready", {31'd0, in_ready}, 32'd0);
          check("bp_hold", {14'd0, cout, ovf, sum}, {14'd0, exp_q[0]});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Back-to-back: one accept per cycle.
    total = 0;
    for (int i = 0; i < 100; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      send(ra, rb, rc, rs, model(ra, rb, rc, rs), w);
      total += w;
    end
    check("b2b_cycles", total, 32'd100);
    drain();

    // Random valid/ready with a full-width carry ripple in the middle.
    rand_rdy = 1'b1;
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      if (i == 12) begin
        send(16'h0FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 16'h1000}, w);
      end else begin
        ra = 16'($urandom); rb = 16'($urandom);
        rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
        send(ra, rb, rc, rs, model(ra, rb, rc, rs), w);
      end
    end
    rand_rdy = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
